// File: rtl/key_voice_pkg.sv
// Shared definitions for the key voice allocator.
// Contents: key/note sizing constants, the per-voice state record, the
// allocator FSM state type and a one-hot helper for clearing pending bits.
package key_voice_pkg;

  localparam int NUM_KEYS    = 32;
  localparam int NOTE_W      = 5;
  localparam int SUSTAIN_BIT = 32;

  // The age field is sized for the widest supported counter (AGE_W up to 16).
  // A narrower AGE_W saturates below this width, so the upper bits stay zero.
  localparam int AGE_MAX_W   = 16;

  typedef struct packed {
    logic                 gate;
    logic                 sustained;
    logic [NOTE_W-1:0]    note;
    logic [AGE_MAX_W-1:0] age;
  } voice_t;

  typedef enum logic {
    IDLE  = 1'b0,
    SERVE = 1'b1
  } state_e;

  function automatic logic [NUM_KEYS-1:0] key_onehot(input logic [NOTE_W-1:0] idx);
    return NUM_KEYS'(1) << idx;
  endfunction

endpackage

// File: rtl/key_event_arbiter.sv
// Lowest-set-bit priority encoder over the 32 key event bits.
// Ports:
//   i_req   : pending event mask, one bit per note key
//   o_valid : any bit of i_req set
//   o_idx   : index of the lowest set bit (0 when o_valid is low)
module key_event_arbiter
  import key_voice_pkg::*;
(
  input  logic [NUM_KEYS-1:0] i_req,
  output logic                o_valid,
  output logic [NOTE_W-1:0]   o_idx
);

  always_comb begin
    o_valid = |i_req;
    o_idx   = '0;
    // Scan downward so the last hit, the lowest index, wins.
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        o_idx = NOTE_W'(i);
      end
    end
  end

endmodule

// File: rtl/key_voice_allocator.sv
// Polyphonic voice allocator. Captures press/release edges of the 32 note
// keys, queues them in pending masks and services one event per cycle,
// assigning pressed notes to a voice pool and stealing the oldest voice when
// the pool is full. The sustain pedal (key bit 32) holds released voices
// until it is lifted.
// Ports:
//   i_clk         : system clock
//   i_rst         : synchronous active-high reset
//   i_key         : key bitmap, [31:0] note keys, [32] sustain pedal
//   o_voice_gate  : per-voice gate (held or sustained)
//   o_voice_note  : per-voice 5-bit note, voice v at [5v+4:5v]
//   o_voice_onset : one-cycle strobe when a voice is (re)assigned
//   o_busy        : high while any press/release event is pending
module key_voice_allocator
  import key_voice_pkg::*;
#(
  parameter int NUM_VOICES = 4,
  parameter int AGE_W      = 8
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic [NUM_KEYS:0]            i_key,
  output logic [NUM_VOICES-1:0]        o_voice_gate,
  output logic [NUM_VOICES*NOTE_W-1:0] o_voice_note,
  output logic [NUM_VOICES-1:0]        o_voice_onset,
  output logic                         o_busy
);

  localparam int VIDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam logic [AGE_MAX_W-1:0] AGE_SAT = AGE_MAX_W'((32'd1 << AGE_W) - 32'd1);

  logic [NUM_KEYS:0]     key_q, key_d;
  logic [NUM_KEYS-1:0]   pend_press_q, pend_press_d;
  logic [NUM_KEYS-1:0]   pend_rel_q, pend_rel_d;
  voice_t                voices_q [NUM_VOICES];
  voice_t                voices_d [NUM_VOICES];
  logic [NUM_VOICES-1:0] onset_q, onset_d;
  state_e                state_q, state_d;

  logic                  rel_vld, press_vld;
  logic [NOTE_W-1:0]     rel_idx, press_idx;

  logic                  rel_hit, match_hit, free_hit;
  logic [VIDX_W-1:0]     rel_v, match_v, free_v, old_v, tgt_v;
  logic [AGE_MAX_W-1:0]  old_age;

  logic                  sus_fall;
  logic [NUM_KEYS-1:0]   press_edge, rel_edge, press_clr, rel_clr;

  key_event_arbiter u_rel_arb (
    .i_req   (pend_rel_q),
    .o_valid (rel_vld),
    .o_idx   (rel_idx)
  );

  key_event_arbiter u_press_arb (
    .i_req   (pend_press_q),
    .o_valid (press_vld),
    .o_idx   (press_idx)
  );

  // Voice lookups: the unsustained voice to release, a gated voice already
  // holding the pressed note, the lowest free voice, and the oldest voice.
  always_comb begin
    rel_hit   = 1'b0;
    rel_v     = '0;
    match_hit = 1'b0;
    match_v   = '0;
    free_hit  = 1'b0;
    free_v    = '0;
    for (int v = NUM_VOICES - 1; v >= 0; v--) begin
      if (voices_q[v].gate && !voices_q[v].sustained && voices_q[v].note == rel_idx) begin
        rel_hit = 1'b1;
        rel_v   = VIDX_W'(v);
      end
      if (voices_q[v].gate && voices_q[v].note == press_idx) begin
        match_hit = 1'b1;
        match_v   = VIDX_W'(v);
      end
      if (!voices_q[v].gate) begin
        free_hit = 1'b1;
        free_v   = VIDX_W'(v);
      end
    end

    // Strict compare keeps the lowest index on equal ages.
    old_v   = '0;
    old_age = voices_q[0].age;
    for (int v = 1; v < NUM_VOICES; v++) begin
      if (voices_q[v].age > old_age) begin
        old_v   = VIDX_W'(v);
        old_age = voices_q[v].age;
      end
    end

    if (match_hit) begin
      tgt_v = match_v;
    end else if (free_hit) begin
      tgt_v = free_v;
    end else begin
      tgt_v = old_v;
    end
  end

  // Event service and pending-mask update.
  always_comb begin
    key_d     = i_key;
    voices_d  = voices_q;
    onset_d   = '0;
    press_clr = '0;
    rel_clr   = '0;
    sus_fall  = key_q[SUSTAIN_BIT] & ~i_key[SUSTAIN_BIT];

    if (sus_fall) begin
      // Pedal lifted: drop every sustained voice; event service waits a cycle.
      for (int v = 0; v < NUM_VOICES; v++) begin
        if (voices_q[v].sustained) begin
          voices_d[v].gate      = 1'b0;
          voices_d[v].sustained = 1'b0;
        end
      end
    end else if (rel_vld) begin
      rel_clr = key_onehot(rel_idx);
      if (rel_hit) begin
        if (i_key[SUSTAIN_BIT]) begin
          voices_d[rel_v].sustained = 1'b1;
        end else begin
          voices_d[rel_v].gate = 1'b0;
        end
      end
    end else if (press_vld) begin
      press_clr = key_onehot(press_idx);
      for (int v = 0; v < NUM_VOICES; v++) begin
        if (voices_q[v].gate && VIDX_W'(v) != tgt_v && voices_q[v].age != AGE_SAT) begin
          voices_d[v].age = voices_q[v].age + 1'b1;
        end
      end
      voices_d[tgt_v].gate      = 1'b1;
      voices_d[tgt_v].sustained = 1'b0;
      voices_d[tgt_v].note      = press_idx;
      voices_d[tgt_v].age       = '0;
      onset_d[tgt_v]            = 1'b1;
    end

    press_edge = i_key[NUM_KEYS-1:0] & ~key_q[NUM_KEYS-1:0];
    rel_edge   = ~i_key[NUM_KEYS-1:0] & key_q[NUM_KEYS-1:0];
    // A pending press whose key is no longer held is discarded.
    pend_press_d = ((pend_press_q & ~press_clr) | press_edge) & i_key[NUM_KEYS-1:0];
    pend_rel_d   = (pend_rel_q & ~rel_clr) | rel_edge;
  end

  always_comb begin
    state_d = IDLE;
    if ((pend_press_d | pend_rel_d) != '0) begin
      state_d = SERVE;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      key_q        <= '0;
      pend_press_q <= '0;
      pend_rel_q   <= '0;
      onset_q      <= '0;
      state_q      <= IDLE;
      for (int v = 0; v < NUM_VOICES; v++) begin
        voices_q[v] <= '0;
      end
    end else begin
      key_q        <= key_d;
      pend_press_q <= pend_press_d;
      pend_rel_q   <= pend_rel_d;
      onset_q      <= onset_d;
      state_q      <= state_d;
      for (int v = 0; v < NUM_VOICES; v++) begin
        voices_q[v] <= voices_d[v];
      end
    end
  end

  for (genvar g = 0; g < NUM_VOICES; g++) begin : g_out
    assign o_voice_gate[g]                   = voices_q[g].gate;
    assign o_voice_note[g*NOTE_W +: NOTE_W]  = voices_q[g].note;
  end

  assign o_voice_onset = onset_q;
  assign o_busy        = (state_q == SERVE);

endmodule
